rf_sb: RTL and testbench
========================

RF_SB -- requirements
Module: rf_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count, a power of two and at least 2; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2: number of asynchronous read ports, at least 1.
REQ-004 SHALL have parameter BYPASS_EN, default 0: 1 forwards same-cycle write data to the read ports.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port i_raddr, input, NRD*AW bits: read addresses; port k uses bits [k*AW +: AW].
REQ-008 SHALL have port o_rdata, output, NRD*XLEN bits: read data; port k uses bits [k*XLEN +: XLEN].
REQ-009 SHALL have port o_rbusy, output, NRD bits: per read port, the addressed register has a pending producer.
REQ-010 SHALL have port i_rd_wen, input, 1 bit: write enable.
REQ-011 SHALL have port i_rd_waddr, input, AW bits: write address.
REQ-012 SHALL have port i_rd_wdata, input, XLEN bits: write data.
REQ-013 SHALL have port i_iss_en, input, 1 bit: issue; marks a destination register pending.
REQ-014 SHALL have port i_iss_addr, input, AW bits: issue destination address.
REQ-015 SHALL have port i_flush, input, 1 bit: clears all pending marks.
REQ-016 SHALL have port o_busy_cnt, output, AW+1 bits: number of currently pending registers.

Function
REQ-017 SHALL hardwire register 0: reads return 0, o_rbusy is 0, and writes and issues to address 0 are ignored.
REQ-018 SHALL update register waddr to wdata on the clock edge when i_rd_wen=1 and waddr!=0, whether or not that register is pending.
REQ-019 SHALL make each read port combinational: o_rdata[k] = regs[raddr_k] and o_rbusy[k] = busy[raddr_k], with zero latency.
REQ-020 SHALL, when BYPASS_EN=1, treat a read port as hit when i_rd_wen=1, waddr=raddr_k and raddr_k!=0.
REQ-021 SHALL, on a bypass hit, make the port return i_rd_wdata and drive o_rbusy[k]=0 in the same cycle.
REQ-022 SHALL, when BYPASS_EN=0, never forward: written data and the cleared busy bit become visible only after the edge.
REQ-023 SHALL keep one busy bit per register, with busy[0] constant 0.
REQ-024 SHALL set busy[a] on the edge when i_iss_en=1 and a=i_iss_addr!=0.
REQ-025 SHALL clear busy[a] on the edge when i_rd_wen=1 and a=i_rd_waddr, unless the issue rule also sets busy[a] in that edge.
REQ-026 SHALL, on issue and write to the same nonzero address in one cycle, write the data and leave the register busy (the new producer wins).
REQ-027 SHALL, on an issue to an already-busy register, keep it busy and leave the count unchanged.
REQ-028 SHALL, on a write to a non-busy register, write the data and leave busy and count unchanged.
REQ-029 SHALL, when i_flush=1, clear all busy bits and set o_busy_cnt=0 on the edge, overriding any same-cycle issue; a same-cycle data write still occurs.
REQ-030 SHALL register o_busy_cnt and keep it equal to the population count of busy[] after every edge.
REQ-031 SHALL update o_busy_cnt per edge by: +1 for a newly set bit, -1 for a newly cleared bit; both events on different addresses give a net 0.
REQ-032 SHALL never wrap o_busy_cnt; its range is 0..NREGS-1.
REQ-033 SHALL give all read ports identical, independent behaviour, so any ports may address the same register.

Reset
REQ-034 SHALL, on an edge with i_rst=1, clear every register to 0, every busy bit to 0 and o_busy_cnt to 0.
REQ-035 SHALL give reset priority over write, issue and flush in the same cycle.
REQ-036 SHALL hold a read of any register at 0 with o_rbusy=0 from the first edge after reset until a write or issue.

Verification
REQ-037 Reset then read addr 5 and addr 31 on ports 0/1 -> rdata 0, rbusy 0, busy_cnt 0.
REQ-038 BYPASS_EN=0: write x3=0xDEADBEEF while port0 reads x3 -> port0 shows old value 0 in that cycle, 0xDEADBEEF after the edge; write x0=0x1234 -> x0 still reads 0.
REQ-039 BYPASS_EN=1: issue x7, next cycle write x7=0xA5A5A5A5 while port1 reads x7 -> same cycle rdata=0xA5A5A5A5, rbusy=0; after the edge busy_cnt=0.
REQ-040 Issue x4, x9, x4 in consecutive cycles -> busy_cnt 1,2,2; same-cycle issue x4 with write x4=0x11 -> x4 reads 0x11, stays busy, count 2.
REQ-041 Issue x2, x3 and x6; then flush in the same cycle as issue x8 -> busy_cnt 0, x8 not busy.
REQ-042 Assert reset mid-stream with busy_cnt=3 and x10=0x55 -> after the edge all reads 0, busy_cnt 0; NRD=4, NREGS=16 build repeats REQ-040.

Source files
------------

// File: rtl/rf_sb.sv
// Integer register file with a per-register scoreboard: asynchronous read ports,
// one write port, issue/flush bookkeeping and a registered pending-register count.
module rf_sb #(
   parameter int XLEN      = 32,
   parameter int NREGS     = 32,
   parameter int NRD       = 2,
   parameter int BYPASS_EN = 0,
   localparam int AW       = $clog2(NREGS)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NRD*AW-1:0]   i_raddr,
   output logic [NRD*XLEN-1:0] o_rdata,
   output logic [NRD-1:0]      o_rbusy,
   input  logic                i_rd_wen,
   input  logic [AW-1:0]       i_rd_waddr,
   input  logic [XLEN-1:0]     i_rd_wdata,
   input  logic                i_iss_en,
   input  logic [AW-1:0]       i_iss_addr,
   input  logic                i_flush,
   output logic [AW:0]         o_busy_cnt
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [AW:0]      cnt_q;
   logic [AW:0]      cnt_d;

   logic wr_hit;
   logic iss_hit;
   logic cnt_inc;
   logic cnt_dec;

   assign wr_hit  = i_rd_wen && (i_rd_waddr != '0);
   assign iss_hit = i_iss_en && (i_iss_addr != '0);

   // The count moves only on real busy transitions; an issue to the same register
   // being written keeps it busy, so that write must not count as a clear.
   assign cnt_inc = iss_hit && !busy_q[i_iss_addr];
   assign cnt_dec = wr_hit && busy_q[i_rd_waddr] && !(iss_hit && (i_iss_addr == i_rd_waddr));

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (wr_hit) begin
         regs_d[i_rd_waddr] = i_rd_wdata;
         busy_d[i_rd_waddr] = 1'b0;
      end
      if (iss_hit) begin
         busy_d[i_iss_addr] = 1'b1;
      end
      if (cnt_inc && !cnt_dec) begin
         cnt_d = cnt_q + (AW+1)'(1);
      end else if (cnt_dec && !cnt_inc) begin
         cnt_d = cnt_q - (AW+1)'(1);
      end
      if (i_flush) begin
         busy_d = '0;
         cnt_d  = '0;
      end
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign o_busy_cnt = cnt_q;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic          byp_hit;

      assign ra      = i_raddr[k*AW +: AW];
      assign byp_hit = (BYPASS_EN != 0) && wr_hit && (i_rd_waddr == ra);

      always_comb begin
         o_rdata[k*XLEN +: XLEN] = (ra == '0) ? '0 : regs_q[ra];
         o_rbusy[k]              = (ra == '0) ? 1'b0 : busy_q[ra];
         if (byp_hit) begin
            o_rdata[k*XLEN +: XLEN] = i_rd_wdata;
            o_rbusy[k]              = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rf_sb.sv
// Self-checking bench: three rf_sb builds (no bypass, bypass, 16x4-port) driven in
// lockstep and compared against an array-based reference model.
module tb_rf_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, wen, iss, flush;
   logic [4:0]  waddr, iss_addr;
   logic [31:0] wdata;
   logic [4:0]  ra [4];

   logic [9:0]  raddr_ab;
   logic [15:0] raddr_c;
   assign raddr_ab = {ra[1], ra[0]};
   assign raddr_c  = {ra[3][3:0], ra[2][3:0], ra[1][3:0], ra[0][3:0]};

   logic [63:0]  rdata_a, rdata_b;
   logic [1:0]   rbusy_a, rbusy_b;
   logic [5:0]   cnt_a, cnt_b;
   logic [127:0] rdata_c;
   logic [3:0]   rbusy_c;
   logic [4:0]   cnt_c;

   rf_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS_EN(0)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_raddr(raddr_ab), .o_rdata(rdata_a), .o_rbusy(rbusy_a),
      .i_rd_wen(wen), .i_rd_waddr(waddr), .i_rd_wdata(wdata), .i_iss_en(iss),
      .i_iss_addr(iss_addr), .i_flush(flush), .o_busy_cnt(cnt_a));

   rf_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS_EN(1)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_raddr(raddr_ab), .o_rdata(rdata_b), .o_rbusy(rbusy_b),
      .i_rd_wen(wen), .i_rd_waddr(waddr), .i_rd_wdata(wdata), .i_iss_en(iss),
      .i_iss_addr(iss_addr), .i_flush(flush), .o_busy_cnt(cnt_b));

   rf_sb #(.XLEN(32), .NREGS(16), .NRD(4), .BYPASS_EN(0)) dut_c (
      .i_clk(clk), .i_rst(rst), .i_raddr(raddr_c), .o_rdata(rdata_c), .o_rbusy(rbusy_c),
      .i_rd_wen(wen), .i_rd_waddr(waddr[3:0]), .i_rd_wdata(wdata), .i_iss_en(iss),
      .i_iss_addr(iss_addr[3:0]), .i_flush(flush), .o_busy_cnt(cnt_c));

   // Model state: index 0 = 32-entry builds, index 1 = 16-entry build
   logic [31:0] mreg  [2][32];
   bit          mbusy [2][32];
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] amask(input int inst, input logic [4:0] a);
      return (inst == 0) ? a : {1'b0, a[3:0]};
   endfunction

   function automatic logic [31:0] exp_data(input int inst, input bit byp, input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (byp && wen && amask(inst, waddr) == a) return wdata;
      return mreg[inst][a];
   endfunction

   function automatic logic exp_busy(input int inst, input bit byp, input logic [4:0] a);
      if (a == 0) return 1'b0;
      if (byp && wen && amask(inst, waddr) == a) return 1'b0;
      return mbusy[inst][a];
   endfunction

   function automatic int popc(input int inst);
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(mbusy[inst][i]);
      return n;
   endfunction

   task automatic model_edge();
      for (int inst = 0; inst < 2; inst++) begin
         if (rst) begin
            for (int i = 0; i < 32; i++) begin
               mreg[inst][i]  = 32'h0;
               mbusy[inst][i] = 1'b0;
            end
         end else begin
            logic [4:0] wa;
            logic [4:0] ia;
            wa = amask(inst, waddr);
            ia = amask(inst, iss_addr);
            if (wen && wa != 0) begin
               mreg[inst][wa]  = wdata;
               mbusy[inst][wa] = 1'b0;
            end
            if (iss && ia != 0) mbusy[inst][ia] = 1'b1;
            if (flush) for (int i = 0; i < 32; i++) mbusy[inst][i] = 1'b0;
         end
      end
   endtask

   task automatic cycle(input bit r, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                        input bit is, input logic [4:0] ia, input bit fl,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3, input bit chk_rd);
      rst = r; wen = w; waddr = wa; wdata = wd; iss = is; iss_addr = ia; flush = fl;
      ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
      #1;
      if (chk_rd) begin
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("a_rdata%0d", p), 64'(rdata_a[p*32 +: 32]), 64'(exp_data(0, 1'b0, ra[p])));
            chk($sformatf("a_rbusy%0d", p), 64'(rbusy_a[p]), 64'(exp_busy(0, 1'b0, ra[p])));
            chk($sformatf("b_rdata%0d", p), 64'(rdata_b[p*32 +: 32]), 64'(exp_data(0, 1'b1, ra[p])));
            chk($sformatf("b_rbusy%0d", p), 64'(rbusy_b[p]), 64'(exp_busy(0, 1'b1, ra[p])));
         end
         for (int p = 0; p < 4; p++) begin
            chk($sformatf("c_rdata%0d", p), 64'(rdata_c[p*32 +: 32]), 64'(exp_data(1, 1'b0, amask(1, ra[p]))));
            chk($sformatf("c_rbusy%0d", p), 64'(rbusy_c[p]), 64'(exp_busy(1, 1'b0, amask(1, ra[p]))));
         end
      end
      @(posedge clk);
      model_edge();
      #1;
      chk("a_busy_cnt", 64'(cnt_a), 64'(popc(0)));
      chk("b_busy_cnt", 64'(cnt_b), 64'(popc(0)));
      chk("c_busy_cnt", 64'(cnt_c), 64'(popc(1)));
   endtask

   initial begin
      @(posedge clk);
      #1;
      // reset state, then idle reads of x5 / x31
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 5, 31, 5, 15, 1);
      // write x3 while reading it; write x0 is ignored
      cycle(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 3, 3, 0, 1);
      cycle(0, 1, 0, 32'h1234, 0, 0, 0, 3, 0, 0, 3, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 3, 1);
      // issue x7 then write it while port1 reads it
      cycle(0, 0, 0, 0, 1, 7, 0, 7, 7, 7, 7, 1);
      cycle(0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 7, 7, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 7, 7, 7, 7, 1);
      // issue x4, x9, x4; issue+write x4 together
      cycle(0, 0, 0, 0, 1, 4, 0, 4, 9, 4, 9, 1);
      cycle(0, 0, 0, 0, 1, 9, 0, 4, 9, 4, 9, 1);
      cycle(0, 0, 0, 0, 1, 4, 0, 4, 9, 4, 9, 1);
      cycle(0, 1, 4, 32'h11, 1, 4, 0, 4, 9, 4, 9, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 4, 9, 4, 9, 1);
      // issue x2, x3, x6, then flush with a same-cycle issue of x8
      cycle(0, 0, 0, 0, 1, 2, 0, 2, 3, 6, 8, 1);
      cycle(0, 0, 0, 0, 1, 3, 0, 2, 3, 6, 8, 1);
      cycle(0, 0, 0, 0, 1, 6, 0, 2, 3, 6, 8, 1);
      cycle(0, 0, 0, 0, 1, 8, 1, 8, 2, 6, 8, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 8, 2, 6, 3, 1);
      // build 3 busy + x10=0x55, then reset over a write/issue/flush
      cycle(0, 0, 0, 0, 1, 2, 0, 2, 10, 2, 10, 1);
      cycle(0, 0, 0, 0, 1, 3, 0, 2, 10, 3, 10, 1);
      cycle(0, 1, 10, 32'h55, 1, 5, 0, 2, 10, 5, 10, 1);
      cycle(1, 1, 10, 32'h99, 1, 11, 1, 10, 2, 10, 11, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 10, 2, 10, 11, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 5, 3, 5, 3, 1);
      // constrained-random traffic
      for (int n = 0; n < 400; n++) begin
         logic [4:0] wa, ia;
         logic [4:0] a [4];
         wa = 5'($urandom);
         ia = ($urandom_range(3) == 0) ? wa : 5'($urandom);
         for (int p = 0; p < 4; p++) a[p] = ($urandom_range(3) == 0) ? wa : 5'($urandom);
         cycle(($urandom_range(63) == 0), 1'($urandom), wa, $urandom, 1'($urandom), ia,
               ($urandom_range(9) == 0), a[0], a[1], a[2], a[3], 1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
